// File: rtl/bram_write_if.sv
// Producer-to-BRAM stream and write-port bundle for bram_write.
// master drives beats and watches the BRAM port; slave is the write stage.
interface bram_write_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  avail_out;
  logic [ADDR_WIDTH-1:0] address_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  write_out;

  modport master (
    output valid_in, data_in,
    input  avail_out, address_out,
    input  data_out, write_out
  );

  modport slave (
    input  valid_in, data_in,
    output avail_out, address_out,
    output data_out, write_out
  );
endinterface

// File: rtl/bram_write.sv
// Stream-to-BRAM write stage: FIFO-buffered beats written over an address window.
// Optional BRAM_WRITE_STATS_EN adds a saturating write_count output.
module bram_write #(
  parameter int DATA_WIDTH              = 8,
  parameter int LOG_MAX_ITERS           = 16,
  parameter int LOG_MAX_WRITES_PER_ITER = 16,
  parameter int LOG_MAX_ADDRESS         = 16,
  parameter int FIFO_SLOTS              = 4,
  parameter int LOG_FIFO_SLOTS          = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               configure,
  input  logic [LOG_MAX_ITERS-1:0]           num_iters,
  input  logic [LOG_MAX_WRITES_PER_ITER-1:0] num_writes_per_iter,
  input  logic [LOG_MAX_ADDRESS-1:0]         base_address,
  bram_write_if.slave                        bus,
  output logic                               done,
  output logic                               overflow
`ifdef BRAM_WRITE_STATS_EN
  ,
  output logic [31:0]                        write_count
`endif
);

  localparam int CW = LOG_FIFO_SLOTS + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_SLOTS);
  localparam logic [CW-1:0] AVAIL_MAX = CW'(FIFO_SLOTS - 3);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [LOG_MAX_ITERS-1:0]           iters_left;
  logic [LOG_MAX_WRITES_PER_ITER-1:0] writes_left;
  logic [LOG_MAX_WRITES_PER_ITER-1:0] writes_copy;
  logic [LOG_MAX_ADDRESS-1:0]         base_copy;
  logic [LOG_MAX_ADDRESS-1:0]         addr;

  logic [DATA_WIDTH-1:0]     mem [FIFO_SLOTS];
  logic [LOG_FIFO_SLOTS-1:0] wr_ptr;
  logic [LOG_FIFO_SLOTS-1:0] rd_ptr;
  logic [CW-1:0]             count;

  logic enabled;
  logic cfg_zero;
  logic pop;
  logic push;
  logic drop;
  logic iter_end;
  logic last;

  assign enabled  = (state == WRITE);
  assign cfg_zero = (num_iters == '0) ||
                    (num_writes_per_iter == '0);
  assign pop      = enabled && (count != '0) && !configure;
  assign push     = bus.valid_in && enabled && (count != FULL_CNT);
  assign drop     = bus.valid_in && !push;
  assign iter_end = (writes_left == LOG_MAX_WRITES_PER_ITER'(1));
  assign last     = iter_end && (iters_left == LOG_MAX_ITERS'(1));

  assign bus.avail_out = enabled && (count <= AVAIL_MAX);
  assign done          = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      configure:
        state_nxt = cfg_zero ? DONE : WRITE;
      pop && last:
        state_nxt = DONE;
      !configure && (state == DONE):
        state_nxt = IDLE;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_SLOTS; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.data_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iters_left  <= '0;
      writes_left <= '0;
      writes_copy <= '0;
      base_copy   <= '0;
      addr        <= '0;
    end else if (configure) begin
      iters_left  <= num_iters;
      writes_left <= num_writes_per_iter;
      writes_copy <= num_writes_per_iter;
      base_copy   <= base_address;
      addr        <= base_address;
    end else if (pop) begin
      // each iteration rewrites the same window from base
      if (iter_end && !last) begin
        iters_left  <= iters_left - 1'b1;
        writes_left <= writes_copy;
        addr        <= base_copy;
      end else begin
        writes_left <= writes_left - 1'b1;
        addr        <= addr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.write_out   <= 1'b0;
      bus.address_out <= '0;
      bus.data_out    <= '0;
    end else begin
      bus.write_out <= pop;
      if (pop) begin
        bus.address_out <= addr;
        bus.data_out    <= mem[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else begin
      if (configure) overflow <= 1'b0;
      if (drop)      overflow <= 1'b1;
    end
  end

`ifdef BRAM_WRITE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      write_count <= '0;
    else if (configure)
      write_count <= '0;
    else if (pop && (write_count != 32'hFFFF_FFFF))
      write_count <= write_count + 1'b1;
  end
`endif

endmodule
